data_memory_responder: RTL and testbench

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

---
 rtl/data_memory_responder_pkg.sv | 33 +++
 rtl/data_memory_responder_dmem_array.sv | 42 ++++
 rtl/data_memory_responder.sv | 114 +++++++++++
 tb/tb_data_memory_responder.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_responder_pkg.sv
// rtl/data_memory_responder_pkg.sv - shared pipeline constants, encodings and FSM state type
package data_memory_responder_pkg;

  localparam int ADDR_W              = 8;
  localparam int DATA_W              = 32;
  localparam int CNT_W               = 4;
  localparam int DEFAULT_WAIT_STATES = 2;

  // Control-signal encodings driven by the MEM stage
  localparam logic RW_LOAD   = 1'b0;
  localparam logic RW_STORE  = 1'b1;
  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } state_t;

  typedef struct packed {
    logic              rw;
    logic              size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  function automatic logic is_misaligned(input logic sz, input logic [ADDR_W-1:0] a);
    return (sz == SIZE_WORD) && (a[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/data_memory_responder_dmem_array.sv
// rtl/data_memory_responder_dmem_array.sv - byte-addressed storage with big-endian word lanes
module dmem_array
  import data_memory_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic              size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [7:0] mem [DEPTH];

  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;
  logic [ADDR_W-1:0] addr3;

  // Lane addresses wrap at 8 bits; aligned words never actually cross the top
  assign addr1 = addr + ADDR_W'(1);
  assign addr2 = addr + ADDR_W'(2);
  assign addr3 = addr + ADDR_W'(3);

  assign rdata = (size == SIZE_WORD) ? {mem[addr], mem[addr1], mem[addr2], mem[addr3]}
                                     : {24'h000000, mem[addr]};

  always_ff @(posedge clk) begin
    if (we) begin
      if (size == SIZE_WORD) begin
        mem[addr]  <= wdata[31:24];
        mem[addr1] <= wdata[23:16];
        mem[addr2] <= wdata[15:8];
        mem[addr3] <= wdata[7:0];
      end else begin
        mem[addr]  <= wdata[7:0];
      end
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - wait-stated MEM-stage data memory responder with alignment check
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int unsigned WAIT_STATES = DEFAULT_WAIT_STATES,
  parameter int unsigned DEPTH       = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              rw,
  input  logic              size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              align_err
);

  state_t            state;
  state_t            state_n;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_n;
  mem_req_t          lat_q;
  logic              capture;
  logic              access_we;
  logic              mis_req;
  logic [DATA_W-1:0] arr_rdata;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  assign mis_req = is_misaligned(size, addr);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    capture   = 1'b0;
    access_we = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          capture = 1'b1;
          // Misaligned words skip the memory entirely and answer with an error
          if (mis_req) begin
            state_n = RESP;
          end else begin
            state_n = WAIT;
            cnt_n   = CNT_W'(WAIT_STATES);
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_n = ACCESS;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      ACCESS: begin
        access_we = (lat_q.rw == RW_STORE);
        state_n   = RESP;
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      lat_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (capture) begin
        lat_q.rw    <= rw;
        lat_q.size  <= size;
        lat_q.addr  <= addr;
        lat_q.wdata <= wdata;
        err_q       <= mis_req;
        rdata_q     <= '0;
      end
      if (state == ACCESS) begin
        rdata_q <= (lat_q.rw == RW_LOAD) ? arr_rdata : '0;
      end
    end
  end

  // Reset low on the ACCESS edge must not commit a store
  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (access_we & reset),
    .size  (lat_q.size),
    .addr  (lat_q.addr),
    .wdata (lat_q.wdata),
    .rdata (arr_rdata)
  );

  assign ready     = (state == RESP);
  assign busy      = (state != IDLE);
  assign rdata     = ready ? rdata_q : '0;
  assign align_err = ready & err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - randomized self-checking bench for data_memory_responder
module tb_data_memory_responder;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        rw = 1'b0;
  logic        size = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [31:0] wdata = 32'h0;
  logic        ready;
  logic [31:0] rdata;
  logic        busy;
  logic        align_err;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] model_mem [256];

  data_memory_responder #(
    .WAIT_STATES (WS),
    .DEPTH       (256)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .rw        (rw),
    .size      (size),
    .addr      (addr),
    .wdata     (wdata),
    .ready     (ready),
    .rdata     (rdata),
    .busy      (busy),
    .align_err (align_err)
  );

  always #5 clk = ~clk;

  // One transaction from an IDLE negedge to its ready negedge; gap = negedges waited for IDLE
  task automatic do_txn(input logic t_rw, input logic t_size, input logic [7:0] t_addr,
                        input logic [31:0] t_wdata, input bit hold, input bit scramble,
                        output int gap, output logic [31:0] got);
    int waited;
    int exp_lat;
    logic exp_err;
    logic [31:0] exp_rd;
    logic [7:0] a0, a1, a2, a3;
    bit seen;
    waited = 0;
    while (busy !== 1'b0 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    gap = waited;
    got = 32'h0;
    vectors++;
    if (busy !== 1'b0 || ready !== 1'b0) begin
      $display("FAIL idle_entry: busy=%b ready=%b, required 0/0", busy, ready);
      miscompares++;
    end
    a0 = t_addr;
    a1 = a0 + 8'd1;
    a2 = a0 + 8'd2;
    a3 = a0 + 8'd3;
    exp_err = t_size && (t_addr[1:0] != 2'b00);
    exp_lat = exp_err ? 1 : WS + 3;
    exp_rd  = 32'h0;
    if (!exp_err) begin
      if (t_rw) begin
        if (t_size) begin
          model_mem[a0] = t_wdata[31:24];
          model_mem[a1] = t_wdata[23:16];
          model_mem[a2] = t_wdata[15:8];
          model_mem[a3] = t_wdata[7:0];
        end else begin
          model_mem[a0] = t_wdata[7:0];
        end
      end else begin
        exp_rd = t_size ? {model_mem[a0], model_mem[a1], model_mem[a2], model_mem[a3]}
                        : {24'h0, model_mem[a0]};
      end
    end
    req = 1'b1; rw = t_rw; size = t_size; addr = t_addr; wdata = t_wdata;
    @(posedge clk);
    seen = 0;
    for (int cyc = 1; cyc <= 30 && !seen; cyc++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        seen = 1;
        got = rdata;
        vectors++;
        if (cyc != exp_lat) begin
          $display("FAIL latency a=%h: got %0d cycles, required %0d", t_addr, cyc, exp_lat);
          miscompares++;
        end
        vectors++;
        if (rdata !== exp_rd) begin
          $display("FAIL rdata a=%h rw=%b sz=%b: got %h, required %h", t_addr, t_rw, t_size, rdata, exp_rd);
          miscompares++;
        end
        vectors++;
        if (align_err !== exp_err) begin
          $display("FAIL align_err a=%h: got %b, required %b", t_addr, align_err, exp_err);
          miscompares++;
        end
        req = hold;
      end else begin
        vectors++;
        if (busy !== 1'b1 || rdata !== 32'h0 || align_err !== 1'b0) begin
          $display("FAIL pending_outputs cyc=%0d: busy=%b rdata=%h err=%b, required 1/0/0",
                   cyc, busy, rdata, align_err);
          miscompares++;
        end
        if (scramble) begin
          rw    = 1'($urandom_range(0, 1));
          size  = 1'($urandom_range(0, 1));
          addr  = 8'($urandom);
          wdata = $urandom;
          req   = hold ? 1'b1 : 1'($urandom_range(0, 1));
        end
      end
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout a=%h: ready never seen, required at cycle %0d", t_addr, exp_lat);
      req = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req = 1'($urandom_range(0, 1)); addr = 8'($urandom); size = 1'b1; rw = 1'b1;
      @(negedge clk);
      vectors++;
      if (ready !== 1'b0 || busy !== 1'b0 || rdata !== 32'h0 || align_err !== 1'b0) begin
        $display("FAIL reset_outputs: ready=%b busy=%b rdata=%h err=%b, required all 0",
                 ready, busy, rdata, align_err);
        miscompares++;
      end
    end
    req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_byte_load;
    int gap;
    logic [31:0] got;
    dut.u_array.mem[8'h05] = 8'hFF;
    model_mem[8'h05] = 8'hFF;
    do_txn(1'b0, 1'b0, 8'h05, 32'h0, 1'b0, 1'b0, gap, got);
    vectors++;
    if (got !== 32'h000000FF) begin
      $display("FAIL byte_load_05: got %h, required 000000ff", got);
      miscompares++;
    end
  endtask

  task automatic test_word_store_load;
    int gap;
    logic [31:0] got;
    logic [31:0] mem_word;
    do_txn(1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 1'b0, gap, got);
    mem_word = {dut.u_array.mem[8'h10], dut.u_array.mem[8'h11], dut.u_array.mem[8'h12], dut.u_array.mem[8'h13]};
    vectors++;
    if (mem_word !== 32'hDEADBEEF) begin
      $display("FAIL word_store_bytes: got %h, required deadbeef", mem_word);
      miscompares++;
    end
    do_txn(1'b0, 1'b1, 8'h10, 32'h0, 1'b0, 1'b0, gap, got);
    vectors++;
    if (got !== 32'hDEADBEEF) begin
      $display("FAIL word_load_10: got %h, required deadbeef", got);
      miscompares++;
    end
    do_txn(1'b1, 1'b0, 8'h11, 32'hFFFFFF5A, 1'b0, 1'b0, gap, got);
    do_txn(1'b0, 1'b1, 8'h10, 32'h0, 1'b0, 1'b0, gap, got);
    vectors++;
    if (got !== 32'hDE5ABEEF) begin
      $display("FAIL byte_overlay: got %h, required de5abeef", got);
      miscompares++;
    end
  endtask

  task automatic test_misaligned;
    int gap;
    logic [31:0] got;
    do_txn(1'b0, 1'b1, 8'h12, 32'h0, 1'b0, 1'b0, gap, got);
    do_txn(1'b1, 1'b1, 8'h13, 32'hA5A5A5A5, 1'b0, 1'b0, gap, got);
    for (int k = 8'h10; k < 8'h18; k++) begin
      vectors++;
      if (dut.u_array.mem[k] !== model_mem[k]) begin
        $display("FAIL misaligned_mem[%h]: got %h, required %h", k, dut.u_array.mem[k], model_mem[k]);
        miscompares++;
      end
    end
  endtask

  task automatic test_boundary;
    int gap;
    logic [31:0] got;
    do_txn(1'b1, 1'b0, 8'hFF, 32'h000000C3, 1'b0, 1'b0, gap, got);
    do_txn(1'b0, 1'b0, 8'hFF, 32'h0, 1'b0, 1'b0, gap, got);
    vectors++;
    if (got !== 32'h000000C3) begin
      $display("FAIL byte_ff: got %h, required 000000c3", got);
      miscompares++;
    end
    do_txn(1'b1, 1'b1, 8'hFC, 32'h0BADF00D, 1'b0, 1'b0, gap, got);
    do_txn(1'b0, 1'b1, 8'hFC, 32'h0, 1'b0, 1'b0, gap, got);
    vectors++;
    if (got !== 32'h0BADF00D) begin
      $display("FAIL word_fc: got %h, required 0badf00d", got);
      miscompares++;
    end
  endtask

  // Store aborted by reset pulled low 'stall' negedges after acceptance
  task automatic test_reset_abort(input int stall, input logic [7:0] a, input logic [31:0] d);
    int waited;
    int ready_seen;
    waited = 0;
    while (busy !== 1'b0 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    req = 1'b1; rw = 1'b1; size = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    ready_seen = 0;
    repeat (stall) begin
      @(negedge clk);
      if (ready === 1'b1) ready_seen++;
    end
    reset = 1'b0;
    req = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || ready !== 1'b0 || rdata !== 32'h0 || align_err !== 1'b0) begin
      $display("FAIL abort_outputs stall=%0d: busy=%b ready=%b rdata=%h err=%b, required all 0",
               stall, busy, ready, rdata, align_err);
      miscompares++;
    end
    reset = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (ready === 1'b1) ready_seen++;
    end
    vectors++;
    if (ready_seen != 0) begin
      $display("FAIL abort_ready stall=%0d: got %0d pulses, required 0", stall, ready_seen);
      miscompares++;
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (dut.u_array.mem[a + k] !== model_mem[a + k]) begin
        $display("FAIL abort_mem[%h]: got %h, required %h", a + k, dut.u_array.mem[a + k], model_mem[a + k]);
        miscompares++;
      end
    end
  endtask

  task automatic test_back_to_back;
    int gap;
    logic [31:0] got;
    logic [7:0] a;
    do_txn(1'b0, 1'b1, 8'h10, 32'h0, 1'b1, 1'b1, gap, got);
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom);
      a[1:0] = 2'b00;
      do_txn(1'($urandom_range(0, 1)), 1'b1, a, $urandom, (i != 5), 1'b1, gap, got);
      vectors++;
      if (gap != 1) begin
        $display("FAIL b2b_gap %0d: got %0d idle waits, required 1", i, gap);
        miscompares++;
      end
    end
  endtask

  task automatic test_random;
    int gap;
    logic [31:0] got;
    for (int i = 0; i < 40; i++) begin
      do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 8'($urandom), $urandom,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), gap, got);
    end
    for (int k = 0; k < 256; k++) begin
      vectors++;
      if (dut.u_array.mem[k] !== model_mem[k]) begin
        $display("FAIL final_mem[%h]: got %h, required %h", k, dut.u_array.mem[k], model_mem[k]);
        miscompares++;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = 8'($urandom);
      dut.u_array.mem[i] = model_mem[i];
    end
    @(negedge clk);
    test_reset();
    test_byte_load();
    test_word_store_load();
    test_misaligned();
    test_boundary();
    test_reset_abort(1, 8'h20, 32'h12345678);
    test_reset_abort(WS + 2, 8'h24, 32'hCAFEF00D);
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
